// File: rtl/vx_gfx_dcr_dispatch.sv
// DCR write dispatcher: decodes each write into one of NUM_GROUPS address windows,
// queues it in that group's FIFO, and supports a flush handshake (drain_req/drain_done).
module vx_gfx_dcr_dispatch #(
   parameter int NUM_GROUPS = 3,
   parameter int ADDR_BITS  = 12,
   parameter int DATA_BITS  = 32,
   parameter int FIFO_DEPTH = 4,
   parameter logic [NUM_GROUPS*ADDR_BITS-1:0] GROUP_BEGIN = {12'h020, 12'h010, 12'h000},
   parameter logic [NUM_GROUPS*ADDR_BITS-1:0] GROUP_END   = {12'h030, 12'h020, 12'h010}
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          in_valid,
   input  logic [ADDR_BITS-1:0]                          in_addr,
   input  logic [DATA_BITS-1:0]                          in_data,
   output logic                                          in_ready,
   output logic [NUM_GROUPS-1:0]                         out_valid,
   output logic [NUM_GROUPS*ADDR_BITS-1:0]               out_addr,
   output logic [NUM_GROUPS*DATA_BITS-1:0]               out_data,
   input  logic [NUM_GROUPS-1:0]                         out_ready,
   input  logic                                          drain_req,
   output logic                                          drain_done,
   output logic [NUM_GROUPS*($clog2(FIFO_DEPTH)+1)-1:0]  pending,
   output logic [15:0]                                   drop_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ADDR_BITS + DATA_BITS;

   typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t                state;
   logic [NUM_GROUPS-1:0] sel_p0;
   logic [NUM_GROUPS-1:0] push_p0;
   logic [NUM_GROUPS-1:0] full;
   logic                  matched_p0;
   logic                  accept_p0;
   logic                  drop_p0;

   // Stage p0: window decode, lowest matching index wins
   always_comb begin
      sel_p0     = '0;
      matched_p0 = 1'b0;
      for (int i = 0; i < NUM_GROUPS; i++) begin
         if (!matched_p0 &&
             in_addr >= GROUP_BEGIN[i*ADDR_BITS +: ADDR_BITS] &&
             in_addr <  GROUP_END[i*ADDR_BITS +: ADDR_BITS]) begin
            sel_p0[i]  = 1'b1;
            matched_p0 = 1'b1;
         end
      end
   end

   // Unmatched writes are always accepted so they can be counted and dropped.
   assign in_ready  = reset && (state == IDLE) && !(|(sel_p0 & full));
   assign accept_p0 = in_valid && in_ready;
   assign push_p0   = accept_p0 ? sel_p0 : '0;
   assign drop_p0   = accept_p0 && !matched_p0;

   // Stage p1: per-group queues, head driven straight from storage
   for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
      logic [ENT_W-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0] wr_ptr;
      logic [PTR_W-1:0] rd_ptr;
      logic [CNT_W-1:0] count;
      logic             pop;

      assign full[g]      = (count == CNT_W'(FIFO_DEPTH));
      assign out_valid[g] = (count != '0);
      assign pop          = out_valid[g] && out_ready[g];

      always_ff @(posedge clk) begin
         if (push_p0[g]) mem[wr_ptr] <= {in_addr, in_data};
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_p0[g]) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)        rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_p0[g], pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end

      assign {out_addr[g*ADDR_BITS +: ADDR_BITS], out_data[g*DATA_BITS +: DATA_BITS]} =
         out_valid[g] ? mem[rd_ptr] : '0;
      assign pending[g*CNT_W +: CNT_W] = count;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         drain_done <= 1'b0;
         drop_count <= '0;
      end else begin
         drain_done <= 1'b0;
         if (drop_p0) drop_count <= sat_inc16(drop_count);
         case (state)
            IDLE:    if (drain_req) state <= DRAIN;
            DRAIN: begin
               if (!(|out_valid)) begin
                  state      <= DONE;
                  drain_done <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
